// File: rtl/distribution_writeback_unit.sv
// distribution_writeback_unit
// Stores a 256-bit distribution to the external SSR as a single SPI mode-0 write
// frame {CMD_WRITE, address, data}, shifted MSB first. The pipeline is stalled
// from request capture until the frame has completed.
module distribution_writeback_unit #(
  parameter int          CLK_DIV   = 4,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter int          ADDR_BITS = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         DUWriteCtrl,
  input  logic [31:0]  rs1,
  input  logic [255:0] du_data,
  output logic         du_wr_stall,
  output logic         du_wr_done,
  output logic         spi_cs_n,
  output logic         spi_sclk,
  output logic         spi_mosi
);

  localparam int NBITS = 8 + ADDR_BITS + 256;
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [NBITS-1:0]   r_shift;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_cs_n;
  logic               r_stall;
  logic               r_done;

  logic               w_div_tc;
  logic               w_last_bit;
  logic               w_start;
  logic               w_fall;
  logic [NBITS-1:0]   w_frame;
  logic               w_stall_nxt;
  logic               w_cs_n_nxt;
  logic               w_done_nxt;
  logic               w_unused_rs1;

  // Upper address bits beyond ADDR_BITS are deliberately dropped.
  assign w_unused_rs1 = ^rs1[31:ADDR_BITS];

  assign w_frame    = {CMD_WRITE, rs1[ADDR_BITS-1:0], du_data};
  assign w_div_tc   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_bit_cnt == BIT_W'(NBITS - 1));
  assign w_start    = (r_state == S_IDLE) && DUWriteCtrl;
  // A falling SCLK toggle is a terminal count while SCLK is currently high.
  assign w_fall     = (r_state == S_SHIFT) && w_div_tc && r_sclk;

  assign du_wr_stall = r_stall;
  assign du_wr_done  = r_done;
  assign spi_cs_n    = r_cs_n;
  assign spi_sclk    = r_sclk;
  assign spi_mosi    = r_mosi;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: setup/hold phases last one SCLK half-period each.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (DUWriteCtrl) w_next_state = S_SETUP;
        else             w_next_state = S_IDLE;
      end
      S_SETUP: begin
        if (w_div_tc) w_next_state = S_SHIFT;
        else          w_next_state = S_SETUP;
      end
      S_SHIFT: begin
        if (w_fall && w_last_bit) w_next_state = S_HOLD;
        else                      w_next_state = S_SHIFT;
      end
      S_HOLD: begin
        if (w_div_tc) w_next_state = S_DONE;
        else          w_next_state = S_HOLD;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it;
  // CS rises on entry to DONE, giving at least two high cycles between frames.
  always_comb begin
    w_stall_nxt = (w_next_state != S_IDLE);
    w_cs_n_nxt  = (w_next_state == S_IDLE) || (w_next_state == S_DONE);
    w_done_nxt  = (w_next_state == S_DONE);
  end

  // Registered control outputs (stall, done, chip select).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= 1'b0;
      r_done  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      r_stall <= w_stall_nxt;
      r_done  <= w_done_nxt;
      r_cs_n  <= w_cs_n_nxt;
    end
  end

  // Half-period divider and SCLK generation; SCLK is forced low outside SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      if ((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD)) begin
        if (w_div_tc) r_div_cnt <= '0;
        else          r_div_cnt <= r_div_cnt + DIV_W'(1);
      end else begin
        r_div_cnt <= '0;
      end
      if ((r_state == S_SHIFT) && w_div_tc) r_sclk <= ~r_sclk;
      else if (r_state != S_SHIFT)          r_sclk <= 1'b0;
      else                                  r_sclk <= r_sclk;
    end
  end

  // Frame shifter: load on request, advance MOSI on each falling SCLK toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_mosi    <= 1'b0;
    end else if (w_start) begin
      r_shift   <= w_frame;
      r_bit_cnt <= '0;
      r_mosi    <= w_frame[NBITS-1];
    end else if (w_fall) begin
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      if (w_last_bit) begin
        r_mosi <= 1'b0;
      end else begin
        r_shift <= r_shift << 1;
        r_mosi  <= r_shift[NBITS-2];
      end
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
      r_mosi    <= r_mosi;
    end
  end

endmodule

// File: tb/tb_distribution_writeback_unit.sv
// Directed testbench for distribution_writeback_unit: an SPI slave model inside
// the cycle-stepping task captures MOSI at each SCLK rise and tracks timing.
module tb_distribution_writeback_unit;

  localparam logic [255:0] PAT = {4{64'h0123456789ABCDEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req_a, req_b;
  logic [31:0]  rs1_a, rs1_b;
  logic [255:0] dat_a, dat_b;
  logic         stall_a, done_a, cs_a, sclk_a, mosi_a;
  logic         stall_b, done_b, cs_b, sclk_b, mosi_b;

  distribution_writeback_unit #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .DUWriteCtrl(req_a), .rs1(rs1_a), .du_data(dat_a),
    .du_wr_stall(stall_a), .du_wr_done(done_a), .spi_cs_n(cs_a),
    .spi_sclk(sclk_a), .spi_mosi(mosi_a)
  );

  distribution_writeback_unit #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .DUWriteCtrl(req_b), .rs1(rs1_b), .du_data(dat_b),
    .du_wr_stall(stall_b), .du_wr_done(done_b), .spi_cs_n(cs_b),
    .spi_sclk(sclk_b), .spi_mosi(mosi_b)
  );

  int total = 0;
  int bad   = 0;

  int cyc, stall_n, done_n, rises, unst, per_err, first_rise, last_rise, cs_fall;
  int hi_run, min_gap, frames;
  int stall_b_n, done_b_n, rises_b;
  logic [575:0] cap;
  logic prev_cs, prev_sclk, prev_mosi, prev_sclk_b;

  // Single comparison point: counts and reports every check.
  task automatic check_val(input string tag, input logic [287:0] got, input logic [287:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    stall_n = 0; done_n = 0; rises = 0; unst = 0; per_err = 0;
    first_rise = -1; last_rise = -1; cs_fall = -1;
    hi_run = 0; min_gap = 1000; frames = 0; cap = '0;
    stall_b_n = 0; done_b_n = 0; rises_b = 0;
  endtask

  // Advance one clock and sample both DUTs on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (stall_a) stall_n++;
    if (done_a) done_n++;
    if (prev_cs && !cs_a) begin
      cs_fall = cyc;
      if (frames > 0 && hi_run < min_gap) min_gap = hi_run;
      frames++;
      hi_run = 0;
      last_rise = -1;
    end
    if (cs_a) hi_run++;
    if (!prev_sclk && sclk_a && !cs_a) begin
      rises++;
      cap = {cap[574:0], mosi_a};
      if (first_rise < 0) first_rise = cyc;
      if (last_rise >= 0 && (cyc - last_rise) != 8) per_err++;
      last_rise = cyc;
      if (mosi_a !== prev_mosi) unst++;
    end
    if (prev_sclk && sclk_a && (mosi_a !== prev_mosi)) unst++;
    prev_cs = cs_a; prev_sclk = sclk_a; prev_mosi = mosi_a;
    if (stall_b) stall_b_n++;
    if (done_b) done_b_n++;
    if (!prev_sclk_b && sclk_b && !cs_b) rises_b++;
    prev_sclk_b = sclk_b;
  endtask

  task automatic pulse_a();
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound);
    int k;
    k = 0;
    while (done_n < n && k < bound) begin
      tick();
      k++;
    end
    check_val("done_in_time", 288'(k < bound), 288'(1));
  endtask

  initial begin
    logic [287:0] exp_f;
    int k;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    rs1_a = 32'h0; rs1_b = 32'h00ABCDEF; dat_a = '0; dat_b = PAT;
    cyc = 0; prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_sclk_b = 1'b0;
    clear_mon();
    repeat (3) tick();
    check_val("reset_outs", 288'({stall_a, done_a, cs_a, sclk_a, mosi_a}), 288'(5'b00100));
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic frame, timing at CLK_DIV=4.
    rs1_a = 32'h00ABCDEF; dat_a = PAT;
    exp_f = {8'h02, 24'hABCDEF, PAT};
    clear_mon();
    pulse_a();
    wait_done(1, 3000);
    check_val("stall_in_done", 288'(stall_a), 288'(1));
    repeat (3) tick();
    check_val("basic_frame", cap[287:0], exp_f);
    check_val("basic_rises", 288'(rises), 288'(288));
    check_val("basic_done_cnt", 288'(done_n), 288'(1));
    check_val("stall_cycles", 288'(stall_n), 288'(2313));
    check_val("cs_to_first_rise", 288'(first_rise - cs_fall), 288'(8));
    check_val("sclk_period_err", 288'(per_err), 288'(0));
    check_val("mosi_unstable", 288'(unst), 288'(0));
    check_val("idle_after", 288'({stall_a, cs_a, sclk_a, mosi_a}), 288'(4'b0100));

    // Reset in the middle of SHIFT, then a clean frame.
    clear_mon();
    pulse_a();
    k = 0;
    while (rises < 101 && k < 3000) begin tick(); k++; end
    check_val("reach_bit100", 288'(k < 3000), 288'(1));
    rst_n = 1'b0;
    #1;
    check_val("abort_outs", 288'({stall_a, done_a, cs_a, sclk_a}), 288'(4'b0010));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rs1_a = 32'h00000055; dat_a = ~PAT;
    clear_mon();
    pulse_a();
    wait_done(1, 3000);
    repeat (3) tick();
    check_val("post_reset_frame", cap[287:0], {8'h02, 24'h000055, ~PAT});
    check_val("post_reset_rises", 288'(rises), 288'(288));

    // Request while busy is ignored.
    rs1_a = 32'h00ABCDEF; dat_a = PAT;
    clear_mon();
    pulse_a();
    k = 0;
    while (rises < 50 && k < 3000) begin tick(); k++; end
    rs1_a = 32'h00111111; dat_a = {4{64'hFEDCBA9876543210}};
    pulse_a();
    wait_done(1, 3000);
    repeat (20) tick();
    check_val("busy_frame", cap[287:0], exp_f);
    check_val("busy_rises", 288'(rises), 288'(288));
    check_val("busy_done_cnt", 288'(done_n), 288'(1));

    // Back-to-back frames with request held high.
    rs1_a = 32'h00ABCDEF; dat_a = PAT;
    clear_mon();
    req_a = 1'b1;
    wait_done(2, 6000);
    req_a = 1'b0;
    repeat (20) tick();
    check_val("b2b_rises", 288'(rises), 288'(576));
    check_val("b2b_done_cnt", 288'(done_n), 288'(2));
    check_val("b2b_frame1", cap[575:288], exp_f);
    check_val("b2b_frame2", cap[287:0], exp_f);
    check_val("b2b_cs_gap_ge2", 288'(min_gap >= 2), 288'(1));
    check_val("b2b_stall_cycles", 288'(stall_n), 288'(4626));

    // Address truncation.
    rs1_a = 32'hFF123456; dat_a = PAT;
    clear_mon();
    pulse_a();
    wait_done(1, 3000);
    repeat (3) tick();
    check_val("trunc_frame", cap[287:0], {8'h02, 24'h123456, PAT});
    check_val("trunc_rises", 288'(rises), 288'(288));

    // CLK_DIV=1 instance latency.
    clear_mon();
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    k = 0;
    while (done_b_n < 1 && k < 1000) begin tick(); k++; end
    check_val("div1_done_in_time", 288'(k < 1000), 288'(1));
    repeat (3) tick();
    check_val("div1_stall_cycles", 288'(stall_b_n), 288'(579));
    check_val("div1_rises", 288'(rises_b), 288'(288));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
